nfc_cmd_queue: RTL

Upstream command stage for the NAND flash controller. Buffers host transfer requests in a small FIFO and validates each request's internal-memory range. Presents one 33-bit command word at a time on the controller's `cmd` input and holds it stable for the whole operation. Tracks the controller's `done` level to decide when the head command has been consumed and retired.

---
 rtl/nfc_cmd_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nfc_cmd_queue.sv
// Command FIFO in front of the NAND flash controller: validates host requests,
// presents the head command on cmd and retires it when the controller goes idle again.
module nfc_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     host_valid,
    input  logic [CW-1:0]            host_cmd,
    output logic                     host_ready,
    output logic                     host_err,
    input  logic                     done,
    output logic [CW-1:0]            cmd,
    output logic                     cmd_valid,
    output logic                     busy,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               cmpl_cnt,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RUN       = 2'd2,
        RUN_EMPTY = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    range_end;
    logic          cmd_ok;
    logic          push;
    logic          reject;
    logic          pop;
    logic [LW-1:0] level_next;

    // Handshake: a request transfers on a rising edge where host_valid and
    // host_ready are both 1; host_valid while host_ready is 0 is simply dropped.
    always_comb begin
        range_end  = {1'b0, host_cmd[13:7]} + {1'b0, host_cmd[6:0]};
        cmd_ok     = (host_cmd[6:0] != 7'd0) && (range_end <= 8'd128);
        push       = host_valid & host_ready & cmd_ok;
        reject     = host_valid & host_ready & ~cmd_ok;
        pop        = (state == RUN) & done;
        level_next = level + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= WAIT_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            cmd_valid  <= 1'b0;
            host_ready <= 1'b1;
            host_err   <= 1'b0;
            cmd        <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            cmpl_cnt   <= 8'd0;
        end else begin
            host_err   <= reject;
            level      <= level_next;
            cmd_valid  <= (level_next != '0);
            host_ready <= (level_next < LW'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                cmpl_cnt <= cmpl_cnt + 8'd1;
            end
            // cmd is frozen for the whole controller operation
            if ((level != '0) && (state != RUN)) begin
                cmd <= mem[rd_ptr];
            end
            case (state)
                WAIT_IDLE: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!done) begin
                        if (cmd_valid) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state    <= RUN_EMPTY;
                            underrun <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN_EMPTY: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
